// File: rtl/mdu_core.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Owns HI/LO and reports Busy while a multiply or divide is in flight.
//
// state | meaning
// IDLE  | no mult/div in flight; accepts new issues and mthi/mtlo
// RUN   | counting down; results are committed to HI/LO on the last busy cycle
module mdu_core #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] phi_q, phi_d;
  logic [31:0] plo_q, plo_d;
  logic        nowrite_q, nowrite_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        issue;
  logic [63:0] mul_s;
  logic [63:0] mul_u;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] b_safe;
  logic [31:0] sdiv_q, srem_q;
  logic [31:0] udiv_q, urem_q;

  assign issue = Start && !Req && (state_q == IDLE);

  assign mul_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign mul_u = {32'd0, A} * {32'd0, B};

  // Substitute a divisor of 1 on divide-by-zero so the dividers never see 0;
  // the result is discarded by the nowrite flag anyway.
  assign div_zero = (B == 32'd0);
  assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign b_safe   = div_zero ? 32'd1 : B;

  always_comb begin
    sdiv_q = 32'h8000_0000;
    srem_q = 32'd0;
    if (!div_ovf) begin
      sdiv_q = 32'($signed(A) / $signed(b_safe));
      srem_q = 32'($signed(A) % $signed(b_safe));
    end
  end

  assign udiv_q = A / b_safe;
  assign urem_q = A % b_safe;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phi_d     = phi_q;
    plo_d     = plo_q;
    nowrite_d = nowrite_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          case (MDUOp)
            OP_MULT: begin
              phi_d     = mul_s[63:32];
              plo_d     = mul_s[31:0];
              nowrite_d = 1'b0;
              cnt_d     = MULT_LOAD;
              state_d   = RUN;
            end
            OP_MULTU: begin
              phi_d     = mul_u[63:32];
              plo_d     = mul_u[31:0];
              nowrite_d = 1'b0;
              cnt_d     = MULT_LOAD;
              state_d   = RUN;
            end
            OP_DIV: begin
              phi_d     = srem_q;
              plo_d     = sdiv_q;
              nowrite_d = div_zero;
              cnt_d     = DIV_LOAD;
              state_d   = RUN;
            end
            OP_DIVU: begin
              phi_d     = urem_q;
              plo_d     = udiv_q;
              nowrite_d = div_zero;
              cnt_d     = DIV_LOAD;
              state_d   = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          if (!nowrite_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      phi_q     <= 32'd0;
      plo_q     <= 32'd0;
      nowrite_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phi_q     <= phi_d;
      plo_q     <= plo_d;
      nowrite_q <= nowrite_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign Busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Out  = (MDUOp == OP_MFHI) ? hi_q :
                (MDUOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_core.sv
// Self-checking bench for mdu_core: directed vector table, corner sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_mdu_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  MDUOp = 4'd0;
  logic        Start = 1'b0;
  logic        Req = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] Out, HI, LO;

  mdu_core #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .MDUOp(MDUOp), .Start(Start), .Req(Req),
    .A(A), .B(B), .Busy(Busy), .Out(Out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the operand values.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    longint x, y, q, r;
    logic [63:0] p;
    case (op)
      4'd1: begin
        x = longint'($signed(a)); y = longint'($signed(b));
        p = 64'(x * y); hi = p[63:32]; lo = p[31:0];
      end
      4'd2: begin
        x = longint'({32'd0, a}); y = longint'({32'd0, b});
        p = 64'(x * y); hi = p[63:32]; lo = p[31:0];
      end
      4'd3: if (b != 0) begin
        x = longint'($signed(a)); y = longint'($signed(b));
        q = x / y; r = x - q * y;
        lo = q[31:0]; hi = r[31:0];
      end
      4'd4: if (b != 0) begin
        x = longint'({32'd0, a}); y = longint'({32'd0, b});
        q = x / y; r = x - q * y;
        lo = q[31:0]; hi = r[31:0];
      end
      4'd7: hi = a;
      4'd8: lo = a;
      default: ;
    endcase
  endfunction

  function automatic int ref_cycles(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd3 || op == 4'd4) return 10;
    return 0;
  endfunction

  // One-cycle issue window; returns at the negedge of the cycle after the issue edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic req);
    @(negedge clk);
    MDUOp = op; A = a; B = b; Start = 1'b1; Req = req;
    @(negedge clk);
    Start = 1'b0; Req = 1'b0; MDUOp = 4'd0;
  endtask

  task automatic wait_idle(output int cyc, output logic [31:0] hi0, output logic [31:0] lo0);
    cyc = 0; hi0 = HI; lo0 = LO;
    while (Busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_out(input string tag);
    MDUOp = 4'd5; #1;
    check({tag, " mfhi"}, Out, m_hi);
    MDUOp = 4'd6; #1;
    check({tag, " mflo"}, Out, m_lo);
    MDUOp = 4'd3; #1;
    check({tag, " out_zero"}, Out, 32'd0);
    MDUOp = 4'd0;
  endtask

  initial begin
    int cyc;
    logic [31:0] hi0, lo0, old_hi, old_lo, ra, rb;
    logic [3:0] rop;

    vecs[0] = '{4'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[4] = '{4'd7, 32'h0000_0011, 32'd0,        32'h0000_0011, 32'h8000_0000, 0};
    vecs[5] = '{4'd8, 32'h0000_0022, 32'd0,        32'h0000_0011, 32'h0000_0022, 0};
    vecs[6] = '{4'd4, 32'd7,         32'd0,        32'h0000_0011, 32'h0000_0022, 10};
    vecs[7] = '{4'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 10};
    vecs[8] = '{4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};

    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, Busy}, 32'd0);
    check("reset hi", HI, 32'd0);
    check("reset lo", LO, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      old_hi = m_hi; old_lo = m_lo;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      wait_idle(cyc, hi0, lo0);
      ref_op(vecs[i].op, vecs[i].a, vecs[i].b, m_hi, m_lo);
      check($sformatf("vec%0d cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      if (vecs[i].exp_cyc > 0) begin
        check($sformatf("vec%0d hold hi", i), hi0, old_hi);
        check($sformatf("vec%0d hold lo", i), lo0, old_lo);
      end
      check($sformatf("vec%0d hi", i), HI, vecs[i].exp_hi);
      check($sformatf("vec%0d lo", i), LO, vecs[i].exp_lo);
      check_out($sformatf("vec%0d", i));
    end

    // Flushed mult: no busy, no change
    issue(4'd1, 32'd3, 32'd4, 1'b1);
    check("req mult busy", {31'd0, Busy}, 32'd0);
    check("req mult hi", HI, m_hi);
    check("req mult lo", LO, m_lo);

    // Flushed mthi
    issue(4'd7, 32'h55, 32'd0, 1'b1);
    check("req mthi hi", HI, m_hi);

    // mtlo while busy is ignored
    issue(4'd1, 32'd3, 32'd4, 1'b0);
    @(negedge clk);
    MDUOp = 4'd8; A = 32'hDEAD_BEEF; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
    wait_idle(cyc, hi0, lo0);
    ref_op(4'd1, 32'd3, 32'd4, m_hi, m_lo);
    check("busy mtlo cycles", 32'(cyc + 2), 32'd5);
    check("busy mtlo lo", LO, 32'd12);
    check("busy mtlo hi", HI, 32'd0);

    // Reset at busy cycle 4 of a divide
    issue(4'd3, 32'd1000, 32'd3, 1'b0);
    repeat (3) @(negedge clk);
    check("pre-reset busy", {31'd0, Busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    check("midreset busy", {31'd0, Busy}, 32'd0);
    check("midreset hi", HI, 32'd0);
    check("midreset lo", LO, 32'd0);
    issue(4'd1, 32'd6, 32'd7, 1'b0);
    wait_idle(cyc, hi0, lo0);
    ref_op(4'd1, 32'd6, 32'd7, m_hi, m_lo);
    check("fresh mult cycles", 32'(cyc), 32'd5);
    check("fresh mult lo", LO, 32'd42);
    check("fresh mult hi", HI, 32'd0);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 10));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 50)) - 32'd25; rb = 32'($urandom_range(0, 10)) - 32'd5; end
        default: ;
      endcase
      issue(rop, ra, rb, 1'b0);
      wait_idle(cyc, hi0, lo0);
      ref_op(rop, ra, rb, m_hi, m_lo);
      check($sformatf("rnd%0d op%0d cycles", i, rop), 32'(cyc), 32'(ref_cycles(rop)));
      check($sformatf("rnd%0d op%0d hi a=%h b=%h", i, rop, ra, rb), HI, m_hi);
      check($sformatf("rnd%0d op%0d lo a=%h b=%h", i, rop, ra, rb), LO, m_lo);
    end
    check_out("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
